// File: rtl/fuzz_iteration_ctrl.sv
// Fuzz iteration controller: sequences DUT reset hold, run with stall/hang/timeout
// watchdog, outcome reporting and the host testcase-reload handshake.
module fuzz_iteration_ctrl #(
    parameter int COV_W        = 30,
    parameter int STALL_CYCLES = 10000,
    parameter int RESET_HOLD   = 16,
    parameter int ITER_W       = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en_i,
    input  logic [63:0]       max_cycles_i,
    input  logic [COV_W-1:0]  cov_i,
    input  logic [63:0]       tohost_i,
    input  logic              reload_ack_i,
    output logic              dut_reset_o,
    output logic              interrupt_o,
    output logic              reload_req_o,
    output logic              done_valid_o,
    output logic [1:0]        done_status_o,
    output logic [ITER_W-1:0] iter_count_o,
    output logic [63:0]       cycle_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_IRQ,
        S_REPORT,
        S_RELOAD
    } state_t;

    localparam logic [1:0]  ST_PASS    = 2'b00;
    localparam logic [1:0]  ST_TIMEOUT = 2'b01;
    localparam logic [1:0]  ST_HANG    = 2'b10;
    localparam logic [31:0] HOLD_LAST  = 32'(RESET_HOLD - 1);
    localparam logic [31:0] STALL_IRQ  = 32'(STALL_CYCLES - 1);
    localparam logic [31:0] STALL_HANG = 32'(2 * STALL_CYCLES - 1);

    state_t            state_q, state_d;
    logic [31:0]       hold_q, hold_d;
    logic [31:0]       stall_q, stall_d;
    logic [COV_W-1:0]  pre_cov_q, pre_cov_d;
    logic [63:0]       cyc_q, cyc_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [1:0]        status_q, status_d;
    logic              dut_reset_q, irq_q, req_q, done_q;

    logic              cov_chg, pass, tmo, running_q, running_d;
    logic [31:0]       stall_inc;

    // Only bit 0 of tohost carries meaning here.
    logic              unused_tohost;
    assign unused_tohost = ^tohost_i[63:1];

    assign cov_chg   = (cov_i != pre_cov_q);
    assign pass      = tohost_i[0];
    assign tmo       = (max_cycles_i != 64'd0) && (cyc_q >= max_cycles_i);
    assign stall_inc = (stall_q == '1) ? stall_q : stall_q + 32'd1;
    assign running_q = (state_q == S_RUN) || (state_q == S_IRQ);
    assign running_d = (state_d == S_RUN) || (state_d == S_IRQ);

    // Next-state and counter update logic.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        stall_d   = stall_q;
        pre_cov_d = pre_cov_q;
        cyc_d     = cyc_q;
        iter_d    = iter_q;
        status_d  = status_q;

        case (state_q)
            S_IDLE: begin
                if (en_i) begin
                    state_d = S_HOLD;
                    hold_d  = 32'd0;
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d   = S_RUN;
                    cyc_d     = 64'd0;
                    stall_d   = 32'd0;
                    pre_cov_d = cov_i;
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end
            S_RUN, S_IRQ: begin
                if (cov_chg) begin
                    pre_cov_d = cov_i;
                    stall_d   = 32'd0;
                end else begin
                    stall_d = stall_inc;
                end
                if (pass) begin
                    state_d  = S_REPORT;
                    status_d = ST_PASS;
                end else if (tmo) begin
                    state_d  = S_REPORT;
                    status_d = ST_TIMEOUT;
                end else if (state_q == S_RUN) begin
                    if (!cov_chg && stall_q == STALL_IRQ) state_d = S_IRQ;
                end else if (cov_chg) begin
                    state_d = S_RUN;
                end else if (stall_q == STALL_HANG) begin
                    state_d  = S_REPORT;
                    status_d = ST_HANG;
                end
            end
            S_REPORT: begin
                state_d = en_i ? S_RELOAD : S_IDLE;
            end
            S_RELOAD: begin
                if (reload_ack_i) begin
                    state_d = S_HOLD;
                    hold_d  = 32'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The run counter freezes on the cycle the outcome is decided, so the
        // reported count is the count at which the condition was seen.
        if (running_q && running_d) cyc_d = cyc_q + 64'd1;
        if (state_d == S_REPORT)    iter_d = iter_q + 1'b1;
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hold_q      <= 32'd0;
            stall_q     <= 32'd0;
            pre_cov_q   <= '0;
            cyc_q       <= 64'd0;
            iter_q      <= '0;
            status_q    <= ST_PASS;
            dut_reset_q <= 1'b1;
            irq_q       <= 1'b0;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            stall_q     <= stall_d;
            pre_cov_q   <= pre_cov_d;
            cyc_q       <= cyc_d;
            iter_q      <= iter_d;
            status_q    <= status_d;
            dut_reset_q <= !running_d;
            irq_q       <= (state_d == S_IRQ);
            req_q       <= (state_d == S_RELOAD);
            done_q      <= (state_d == S_REPORT);
        end
    end

    assign dut_reset_o   = dut_reset_q;
    assign interrupt_o   = irq_q;
    assign reload_req_o  = req_q;
    assign done_valid_o  = done_q;
    assign done_status_o = status_q;
    assign iter_count_o  = iter_q;
    assign cycle_count_o = cyc_q;

endmodule

// File: tb/tb_fuzz_iteration_ctrl.sv
// Directed bench for fuzz_iteration_ctrl: a vector table for the timeout/priority/
// reload basics, then hand sequences for pass, stall recovery, hang and reset-in-IRQ.
module tb_fuzz_iteration_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        reload_ack = 1'b0;
    logic [63:0] max_cycles = 64'd0;
    logic [63:0] tohost = 64'd0;
    logic [29:0] cov = 30'd0;
    logic        dut_reset, interrupt, reload_req, done_valid;
    logic [1:0]  done_status;
    logic [31:0] iter_count;
    logic [63:0] cycle_count;

    int errs = 0;
    int checks = 0;

    fuzz_iteration_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .en_i         (en),
        .max_cycles_i (max_cycles),
        .cov_i        (cov),
        .tohost_i     (tohost),
        .reload_ack_i (reload_ack),
        .dut_reset_o  (dut_reset),
        .interrupt_o  (interrupt),
        .reload_req_o (reload_req),
        .done_valid_o (done_valid),
        .done_status_o(done_status),
        .iter_count_o (iter_count),
        .cycle_count_o(cycle_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst, en, ack, toh;
        logic [63:0] maxc;
        logic [29:0] cov;
        int          n;
        logic        dr, irq, req, dv;
        logic [1:0]  st;
        logic [31:0] it;
        logic [63:0] cyc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic e, logic ack, logic toh, logic [63:0] maxc,
                                logic [29:0] c, int n, logic dr, logic irq, logic req,
                                logic dv, logic [1:0] st, logic [31:0] it, logic [63:0] cyc);
        vec_t v;
        v.rst = rst; v.en = e; v.ack = ack; v.toh = toh; v.maxc = maxc; v.cov = c; v.n = n;
        v.dr = dr; v.irq = irq; v.req = req; v.dv = dv; v.st = st; v.it = it; v.cyc = cyc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // HOLD phase already entered: 16 cycles of dut_reset, then RUN at count 0.
    task automatic hold16(input string tag);
        repeat (15) step();
        chk({tag, ".hold_dut_reset"}, dut_reset, 1);
        step();
        chk({tag, ".run_dut_reset"}, dut_reset, 0);
        chk({tag, ".run_cycle0"}, cycle_count, 0);
    endtask

    task automatic start_run(input string tag);
        en = 1'b1;
        step();
        chk({tag, ".hold_entry"}, dut_reset, 1);
        en = 1'b0;
        hold16(tag);
    endtask

    initial begin
        int bad;
        int r;

        //           rst en ack toh max cov  n    | dr irq req dv st it cyc
        tbl.push_back(mk(1, 0, 0, 0, 300, 5,   2,   1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 300, 5,   3,   1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 300, 5,   1,   1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 300, 5,  15,   1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 300, 5,   1,   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 300, 6, 299,   0, 0, 0, 0, 0, 0, 299));
        tbl.push_back(mk(0, 0, 0, 0, 300, 7,   1,   0, 0, 0, 0, 0, 0, 300));
        tbl.push_back(mk(0, 0, 0, 0, 300, 7,   1,   1, 0, 0, 1, 1, 1, 300));
        tbl.push_back(mk(0, 0, 0, 0, 300, 7,   1,   1, 0, 0, 0, 1, 1, 300));
        tbl.push_back(mk(0, 0, 0, 0, 300, 7,   5,   1, 0, 0, 0, 1, 1, 300));
        tbl.push_back(mk(0, 1, 0, 0, 300, 7,   1,   1, 0, 0, 0, 1, 1, 300));
        tbl.push_back(mk(0, 0, 0, 0, 300, 7,  16,   0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 300, 8, 300,   0, 0, 0, 0, 1, 1, 300));
        tbl.push_back(mk(0, 0, 0, 1, 300, 8,   1,   1, 0, 0, 1, 0, 2, 300));
        tbl.push_back(mk(0, 1, 0, 0, 300, 8,   1,   1, 0, 1, 0, 0, 2, 300));
        tbl.push_back(mk(0, 0, 0, 0, 300, 8,   3,   1, 0, 1, 0, 0, 2, 300));
        tbl.push_back(mk(0, 0, 1, 0, 300, 8,   1,   1, 0, 0, 0, 0, 2, 300));
        tbl.push_back(mk(0, 0, 0, 0, 300, 8,  16,   0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, 0, 1, 0, 300, 8,   5,   0, 0, 0, 0, 0, 2, 5));
        tbl.push_back(mk(1, 0, 0, 0, 300, 8,   1,   1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,   0, 8,   2,   1, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; en = tbl[i].en; reload_ack = tbl[i].ack;
            tohost = {63'd0, tbl[i].toh}; max_cycles = tbl[i].maxc; cov = tbl[i].cov;
            repeat (tbl[i].n) step();
            chk($sformatf("vec%0d.dut_reset", i),   dut_reset,   tbl[i].dr);
            chk($sformatf("vec%0d.interrupt", i),   interrupt,   tbl[i].irq);
            chk($sformatf("vec%0d.reload_req", i),  reload_req,  tbl[i].req);
            chk($sformatf("vec%0d.done_valid", i),  done_valid,  tbl[i].dv);
            chk($sformatf("vec%0d.done_status", i), done_status, tbl[i].st);
            chk($sformatf("vec%0d.iter_count", i),  iter_count,  tbl[i].it);
            chk($sformatf("vec%0d.cycle_count", i), cycle_count, tbl[i].cyc);
        end

        // Pass path: cov steps every 100 run cycles, tohost at run cycle 500.
        start_run("pass");
        bad = 0;
        for (r = 0; r < 500; r++) begin
            if (cycle_count != 64'(r) || done_valid || dut_reset || interrupt) bad++;
            cov = 30'(r / 100);
            step();
        end
        chk("pass.run_trace", bad, 0);
        chk("pass.cycle500", cycle_count, 500);
        tohost = 64'd1; en = 1'b1;
        step();
        tohost = 64'd0;
        chk("pass.done_valid", done_valid, 1);
        chk("pass.status", done_status, 0);
        chk("pass.cycle_count", cycle_count, 500);
        chk("pass.iter", iter_count, 1);
        chk("pass.dut_reset", dut_reset, 1);

        // Reload with ack delayed 50 cycles.
        step();
        en = 1'b0;
        chk("reload.req_first", reload_req, 1);
        bad = 0;
        repeat (49) begin
            step();
            if (!reload_req || !dut_reset) bad++;
        end
        chk("reload.held50", bad, 0);
        reload_ack = 1'b1;
        step();
        reload_ack = 1'b0;
        chk("reload.req_drop", reload_req, 0);
        chk("reload.hold_dut_reset", dut_reset, 1);
        hold16("reload");
        repeat (10) step();
        tohost = 64'd1; en = 1'b1; reload_ack = 1'b1;
        step();
        tohost = 64'd0;
        chk("iter2.count", iter_count, 2);
        chk("iter2.cycle", cycle_count, 10);

        // Same-cycle ack: ack already high on the first RELOAD cycle.
        step();
        en = 1'b0;
        chk("sameack.req", reload_req, 1);
        step();
        reload_ack = 1'b0;
        chk("sameack.req_drop", reload_req, 0);
        chk("sameack.dut_reset", dut_reset, 1);
        hold16("sameack");
        tohost = 64'd1;
        step();
        tohost = 64'd0;
        chk("iter3.count", iter_count, 3);
        chk("iter3.cycle", cycle_count, 0);
        step();
        chk("iter3.idle_req", reload_req, 0);
        chk("iter3.idle_done", done_valid, 0);

        // Stall then recovery by a coverage change at run cycle 10200.
        start_run("stall");
        bad = 0;
        for (r = 0; r < 10300; r++) begin
            if (cycle_count != 64'(r) || interrupt != (r >= 10000 && r <= 10200) || done_valid) bad++;
            if (r == 9999)  chk("stall.irq_9999", interrupt, 0);
            if (r == 10000) chk("stall.irq_10000", interrupt, 1);
            if (r == 10200) begin
                chk("stall.irq_10200", interrupt, 1);
                cov = cov + 30'd1;
            end
            if (r == 10201) chk("stall.irq_10201", interrupt, 0);
            step();
        end
        chk("stall.trace", bad, 0);
        tohost = 64'd1;
        step();
        tohost = 64'd0;
        chk("stall.done_valid", done_valid, 1);
        chk("stall.status", done_status, 0);
        chk("stall.cycle", cycle_count, 10300);
        chk("stall.iter", iter_count, 4);
        step();

        // Hang: coverage never moves and tohost never rises.
        start_run("hang");
        bad = 0;
        for (r = 0; r < 20000; r++) begin
            if (cycle_count != 64'(r) || interrupt != (r >= 10000) || done_valid) bad++;
            step();
        end
        chk("hang.trace", bad, 0);
        chk("hang.done_valid", done_valid, 1);
        chk("hang.status", done_status, 2);
        chk("hang.dut_reset", dut_reset, 1);
        chk("hang.interrupt", interrupt, 0);
        chk("hang.cycle", cycle_count, 19999);
        chk("hang.iter", iter_count, 5);
        step();
        chk("hang.idle_req", reload_req, 0);

        // Reset while in IRQ aborts without a done pulse.
        start_run("rst");
        repeat (10005) step();
        chk("rst.in_irq", interrupt, 1);
        reset = 1'b1;
        step();
        chk("rst.dut_reset", dut_reset, 1);
        chk("rst.interrupt", interrupt, 0);
        chk("rst.reload_req", reload_req, 0);
        chk("rst.done_valid", done_valid, 0);
        chk("rst.status", done_status, 0);
        chk("rst.iter", iter_count, 0);
        chk("rst.cycle", cycle_count, 0);
        reset = 1'b0;
        step();
        chk("rst.idle_done", done_valid, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
